// File: rtl/aes_round_sequencer.sv
// ---------------------------------------------------------------------------
// aes_round_sequencer
//
// Sequences the AES-128 round datapath for the 16-bit CPU.
//
// The CPU writes a 128-bit state and a 128-bit key as 16-bit words and then
// pulses start. This block applies the initial AddRoundKey itself. It then
// hands each round to an external round unit over a req/ack handshake.
//
//   Encrypt : INIT (state ^= K0), then rounds 1..10 with op 0.
//   Decrypt : KEXP (forward key steps 1..10 with op 2, which leaves K10 in
//             the key register), then INIT (state ^= K10), then inverse
//             rounds 10..1 with op 1.
//
// The result is held in its own register, so CPU loads always see the last
// completed block.
//
// Ports
//   clk_i        clock
//   reset        synchronous, active-high reset
//   wr_en_i      CPU word write strobe (honoured only while idle)
//   wr_addr_i    0-7 state words, 8-15 key words; word 0 is bits [127:112]
//   wr_data_i    write data
//   start_i      launch an operation (sampled only while idle)
//   decrypt_i    mode, sampled with start_i (0 encrypt, 1 decrypt)
//   busy_o       operation in progress
//   done_o       one-cycle completion pulse
//   rd_addr_i    result word select; word 0 is bits [127:112]
//   rd_data_o    result word (combinational from the result register)
//   rnd_req_o    round request to the datapath
//   rnd_op_o     0 enc round, 1 dec round, 2 forward key step
//   rnd_idx_o    round number 1..10 (enc/key) or 10..1 (dec)
//   rnd_final_o  last round of the pass (no (Inv)MixColumns)
//   rnd_state_o  current state presented to the round unit
//   rnd_key_o    current round key presented to the round unit
//   rnd_ack_i    round unit result valid
//   rnd_state_i  next state from the round unit
//   rnd_key_i    next round key (forward for op 0/2, previous for op 1)
// ---------------------------------------------------------------------------
module aes_round_sequencer #(
    parameter int NUM_ROUNDS = 10,
    parameter int DW         = 16
) (
    input  logic          clk_i,
    input  logic          reset,
    input  logic          wr_en_i,
    input  logic [3:0]    wr_addr_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic          start_i,
    input  logic          decrypt_i,
    output logic          busy_o,
    output logic          done_o,
    input  logic [2:0]    rd_addr_i,
    output logic [DW-1:0] rd_data_o,
    output logic          rnd_req_o,
    output logic [1:0]    rnd_op_o,
    output logic [3:0]    rnd_idx_o,
    output logic          rnd_final_o,
    output logic [127:0]  rnd_state_o,
    output logic [127:0]  rnd_key_o,
    input  logic          rnd_ack_i,
    input  logic [127:0]  rnd_state_i,
    input  logic [127:0]  rnd_key_i
);

    localparam int         NW       = 128 / DW;
    localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);
    localparam logic [1:0] OP_ENC   = 2'd0;
    localparam logic [1:0] OP_DEC   = 2'd1;
    localparam logic [1:0] OP_KEY   = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEXP,
        S_INIT,
        S_ROUND,
        S_DONE
    } state_t;

    state_t       fsm;
    logic         dec_mode;
    logic [127:0] state_reg;
    logic [127:0] key_reg;
    logic [127:0] result_reg;

    assign rnd_state_o = state_reg;
    assign rnd_key_o   = key_reg;

    // Sequencer FSM. Every handshake output is registered. This keeps req,
    // op, idx and final stable while the round unit takes its time to ack.
    // The result register is loaded on the final ack. That way the result is
    // already readable during the done_o pulse.
    always_ff @(posedge clk_i) begin
        if (reset) begin
            fsm         <= S_IDLE;
            dec_mode    <= 1'b0;
            state_reg   <= '0;
            key_reg     <= '0;
            result_reg  <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            rnd_req_o   <= 1'b0;
            rnd_op_o    <= OP_ENC;
            rnd_idx_o   <= 4'd0;
            rnd_final_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (fsm)
                S_IDLE: begin
                    // A write in the start cycle lands before the INIT/KEXP
                    // cycle reads the buffers, so the new word is used.
                    if (wr_en_i) begin
                        for (int w = 0; w < NW; w++) begin
                            if (wr_addr_i[2:0] == w[2:0]) begin
                                if (wr_addr_i[3])
                                    key_reg[127-DW*w -: DW] <= wr_data_i;
                                else
                                    state_reg[127-DW*w -: DW] <= wr_data_i;
                            end
                        end
                    end
                    if (start_i) begin
                        busy_o   <= 1'b1;
                        dec_mode <= decrypt_i;
                        if (decrypt_i) begin
                            fsm         <= S_KEXP;
                            rnd_req_o   <= 1'b1;
                            rnd_op_o    <= OP_KEY;
                            rnd_idx_o   <= 4'd1;
                            rnd_final_o <= 1'b0;
                        end else begin
                            fsm <= S_INIT;
                        end
                    end
                end

                S_KEXP: begin
                    // Only the key advances; the state waits for INIT.
                    if (rnd_ack_i) begin
                        key_reg <= rnd_key_i;
                        if (rnd_idx_o == LAST_IDX) begin
                            fsm       <= S_INIT;
                            rnd_req_o <= 1'b0;
                        end else begin
                            rnd_idx_o <= rnd_idx_o + 4'd1;
                        end
                    end
                end

                S_INIT: begin
                    // The key register holds K0 (encrypt) or K10 (decrypt).
                    state_reg <= state_reg ^ key_reg;
                    fsm       <= S_ROUND;
                    rnd_req_o <= 1'b1;
                    rnd_op_o  <= dec_mode ? OP_DEC : OP_ENC;
                    rnd_idx_o <= dec_mode ? LAST_IDX : 4'd1;
                    rnd_final_o <= (LAST_IDX == 4'd1);
                end

                S_ROUND: begin
                    if (rnd_ack_i) begin
                        state_reg <= rnd_state_i;
                        key_reg   <= rnd_key_i;
                        if (rnd_final_o) begin
                            fsm         <= S_DONE;
                            rnd_req_o   <= 1'b0;
                            rnd_final_o <= 1'b0;
                            busy_o      <= 1'b0;
                            done_o      <= 1'b1;
                            result_reg  <= rnd_state_i;
                        end else if (dec_mode) begin
                            rnd_idx_o   <= rnd_idx_o - 4'd1;
                            rnd_final_o <= (rnd_idx_o == 4'd2);
                        end else begin
                            rnd_idx_o   <= rnd_idx_o + 4'd1;
                            rnd_final_o <= ((rnd_idx_o + 4'd1) == LAST_IDX);
                        end
                    end
                end

                S_DONE: begin
                    fsm <= S_IDLE;
                end

                default: begin
                    fsm <= S_IDLE;
                end
            endcase
        end
    end

    // CPU read port: select one word of the last completed result.
    always_comb begin
        rd_data_o = '0;
        for (int w = 0; w < NW; w++) begin
            if (rd_addr_i == w[2:0])
                rd_data_o = result_reg[127-DW*w -: DW];
        end
    end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// ---------------------------------------------------------------------------
// tb_aes_round_sequencer
//
// Bench for aes_round_sequencer. A behavioural AES round unit answers the
// handshake with random ack delays. Results are compared against a
// full-cipher reference built from a precomputed key schedule, and against
// FIPS-197 known-answer vectors.
// ---------------------------------------------------------------------------
module tb_aes_round_sequencer;

    logic         clk = 1'b0;
    logic         reset;
    logic         wr_en_i;
    logic [3:0]   wr_addr_i;
    logic [15:0]  wr_data_i;
    logic         start_i;
    logic         decrypt_i;
    logic         busy_o;
    logic         done_o;
    logic [2:0]   rd_addr_i;
    logic [15:0]  rd_data_o;
    logic         rnd_req_o;
    logic [1:0]   rnd_op_o;
    logic [3:0]   rnd_idx_o;
    logic         rnd_final_o;
    logic [127:0] rnd_state_o;
    logic [127:0] rnd_key_o;
    logic         rnd_ack_i;
    logic [127:0] rnd_state_i;
    logic [127:0] rnd_key_i;

    int checks = 0;
    int passed = 0;
    int max_delay = 0;
    int hs_count = 0;
    int done_count = 0;
    logic [6:0] hs_log [$];

    logic [7:0] sbox_t [256];
    logic [7:0] isbox_t [256];

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] FIPS_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] C1_KEY   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    aes_round_sequencer #(.NUM_ROUNDS(10), .DW(16)) dut (
        .clk_i      (clk),
        .reset      (reset),
        .wr_en_i    (wr_en_i),
        .wr_addr_i  (wr_addr_i),
        .wr_data_i  (wr_data_i),
        .start_i    (start_i),
        .decrypt_i  (decrypt_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .rd_addr_i  (rd_addr_i),
        .rd_data_o  (rd_data_o),
        .rnd_req_o  (rnd_req_o),
        .rnd_op_o   (rnd_op_o),
        .rnd_idx_o  (rnd_idx_o),
        .rnd_final_o(rnd_final_o),
        .rnd_state_o(rnd_state_o),
        .rnd_key_o  (rnd_key_o),
        .rnd_ack_i  (rnd_ack_i),
        .rnd_state_i(rnd_state_i),
        .rnd_key_i  (rnd_key_i)
    );

    always #10 clk = ~clk;

    // ---------------- AES primitives ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    // S-box from the GF(2^8) inverse plus the affine map.
    task automatic init_tables();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            logic [7:0] b;
            logic [7:0] s;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            b = inv;
            s = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
            sbox_t[x] = s;
            isbox_t[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
        for (int b = 0; b < 16; b++)
            s[127-8*b -: 8] = inv ? isbox_t[s[127-8*b -: 8]] : sbox_t[s[127-8*b -: 8]];
        return s;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
        logic [127:0] o = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                int dst = r + 4 * c;
                int src = r + 4 * ((c + r) % 4);
                if (!inv) o[127-8*dst -: 8] = s[127-8*src -: 8];
                else      o[127-8*src -: 8] = s[127-8*dst -: 8];
            end
        return o;
    endfunction

    function automatic logic [127:0] mix(input logic [127:0] s, input logic inv);
        logic [127:0] o = '0;
        logic [7:0] m [4];
        logic [7:0] a [4];
        if (inv) begin m[0] = 8'd14; m[1] = 8'd11; m[2] = 8'd13; m[3] = 8'd9; end
        else     begin m[0] = 8'd2;  m[1] = 8'd3;  m[2] = 8'd1;  m[3] = 8'd1; end
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) a[j] = s[127-8*(4*c+j) -: 8];
            for (int r = 0; r < 4; r++) begin
                logic [7:0] acc = 8'h00;
                for (int j = 0; j < 4; j++) acc = acc ^ gmul(a[j], m[(j - r + 4) % 4]);
                o[127-8*(4*c+r) -: 8] = acc;
            end
        end
        return o;
    endfunction

    function automatic logic [7:0] rcon(input int i);
        logic [7:0] r = 8'h01;
        for (int k = 1; k < i; k++) r = xt(r);
        return r;
    endfunction

    function automatic logic [31:0] rot_sub(input logic [31:0] w);
        return {sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]], sbox_t[w[31:24]]};
    endfunction

    function automatic logic [127:0] key_fwd(input logic [127:0] k, input int i);
        logic [31:0] w0, w1, w2, w3;
        w0 = k[127:96] ^ rot_sub(k[31:0]) ^ {rcon(i), 24'h0};
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] key_inv(input logic [127:0] k, input int i);
        logic [31:0] w0, w1, w2, w3;
        w3 = k[31:0] ^ k[63:32];
        w2 = k[63:32] ^ k[95:64];
        w1 = k[95:64] ^ k[127:96];
        w0 = k[127:96] ^ rot_sub(w3) ^ {rcon(i), 24'h0};
        return {w0, w1, w2, w3};
    endfunction

    // Whole-block reference cipher built from a precomputed key schedule.
    function automatic logic [127:0] aes_ref(input logic dec, input logic [127:0] blk,
                                             input logic [127:0] key);
        logic [127:0] ks [11];
        logic [127:0] s;
        ks[0] = key;
        for (int i = 1; i <= 10; i++) ks[i] = key_fwd(ks[i-1], i);
        if (!dec) begin
            s = blk ^ ks[0];
            for (int r = 1; r <= 10; r++) begin
                s = shift_rows(sub_bytes(s, 1'b0), 1'b0);
                if (r < 10) s = mix(s, 1'b0);
                s = s ^ ks[r];
            end
        end else begin
            s = blk ^ ks[10];
            for (int r = 9; r >= 0; r--) begin
                s = sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ ks[r];
                if (r > 0) s = mix(s, 1'b1);
            end
        end
        return s;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [263:0] act, input logic [263:0] req);
        checks++;
        if (act === req) passed++;
        else $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    endtask

    // Behavioural round unit: random ack delay, outputs computed on ack.
    initial begin : responder
        bit fresh = 1'b1;
        bit waiting = 1'b0;
        int wait_cnt = 0;
        logic [262:0] snap = '0;
        logic [127:0] s;
        logic [127:0] k;
        rnd_ack_i = 1'b0;
        rnd_state_i = '0;
        rnd_key_i = '0;
        forever begin
            @(negedge clk);
            rnd_ack_i = 1'b0;
            if (reset || !rnd_req_o) begin
                fresh = 1'b1;
                waiting = 1'b0;
            end else begin
                if (waiting)
                    check("req_stable", {rnd_op_o, rnd_idx_o, rnd_final_o, rnd_state_o, rnd_key_o}, snap);
                if (fresh) begin
                    wait_cnt = (max_delay > 0) ? int'($urandom_range(0, max_delay)) : 0;
                    fresh = 1'b0;
                end
                if (wait_cnt == 0) begin
                    case (rnd_op_o)
                        2'd0: begin
                            k = key_fwd(rnd_key_o, int'(rnd_idx_o));
                            s = shift_rows(sub_bytes(rnd_state_o, 1'b0), 1'b0);
                            if (!rnd_final_o) s = mix(s, 1'b0);
                            rnd_state_i = s ^ k;
                            rnd_key_i = k;
                        end
                        2'd1: begin
                            k = key_inv(rnd_key_o, int'(rnd_idx_o));
                            s = sub_bytes(shift_rows(rnd_state_o, 1'b1), 1'b1) ^ k;
                            if (!rnd_final_o) s = mix(s, 1'b1);
                            rnd_state_i = s;
                            rnd_key_i = k;
                        end
                        2'd2: begin
                            rnd_key_i = key_fwd(rnd_key_o, int'(rnd_idx_o));
                            rnd_state_i = {$urandom, $urandom, $urandom, $urandom};
                        end
                        default: begin
                            rnd_state_i = rnd_state_o;
                            rnd_key_i = rnd_key_o;
                        end
                    endcase
                    rnd_ack_i = 1'b1;
                    hs_log.push_back({rnd_op_o, rnd_idx_o, rnd_final_o});
                    hs_count++;
                    fresh = 1'b1;
                    waiting = 1'b0;
                end else begin
                    wait_cnt--;
                    waiting = 1'b1;
                    snap = {rnd_op_o, rnd_idx_o, rnd_final_o, rnd_state_o, rnd_key_o};
                end
            end
        end
    end

    always @(negedge clk) if (done_o === 1'b1) done_count++;

    initial begin : watchdog
        repeat (50000) @(posedge clk);
        $display("[TB] FAIL watchdog actual=%0d required=%0d", 50000, 0);
        $display("%0d/%0d checks passed", passed, checks + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    // ---------------- stimulus tasks ----------------
    task automatic write_word(input logic [3:0] addr, input logic [15:0] data);
        wr_en_i = 1'b1;
        wr_addr_i = addr;
        wr_data_i = data;
        @(negedge clk);
        wr_en_i = 1'b0;
    endtask

    task automatic load_block(input logic [127:0] blk, input logic [127:0] key);
        for (int w = 0; w < 8; w++) write_word(4'(w), blk[127-16*w -: 16]);
        for (int w = 0; w < 8; w++) write_word(4'(8 + w), key[127-16*w -: 16]);
    endtask

    task automatic read_result(output logic [127:0] r);
        r = '0;
        for (int w = 0; w < 8; w++) begin
            rd_addr_i = w[2:0];
            #1;
            r[127-16*w -: 16] = rd_data_o;
        end
    endtask

    // Runs one operation from the start cycle (cycle 1) to the done pulse.
    task automatic run_op(input logic dec, input logic same_wr, input logic [3:0] sw_addr,
                          input logic [15:0] sw_data, input logic busy_inj,
                          output int lat, output logic [127:0] res);
        int cyc = 1;
        int bad = 0;
        int n = dec ? 20 : 10;
        lat = -1;
        hs_count = 0;
        hs_log.delete();
        start_i = 1'b1;
        decrypt_i = dec;
        if (same_wr) begin
            wr_en_i = 1'b1;
            wr_addr_i = sw_addr;
            wr_data_i = sw_data;
        end
        @(posedge clk);
        cyc = 2;
        @(negedge clk);
        start_i = 1'b0;
        decrypt_i = 1'b0;
        wr_en_i = 1'b0;
        check("busy_rise", busy_o, 1'b1);
        while (cyc < 2000) begin
            if (done_o) begin
                lat = cyc;
                break;
            end
            if (busy_inj && cyc == 5) begin
                wr_en_i = 1'b1;
                wr_addr_i = 4'd3;
                wr_data_i = 16'hFFFF;
                start_i = 1'b1;
                decrypt_i = ~dec;
            end
            @(posedge clk);
            cyc++;
            @(negedge clk);
            wr_en_i = 1'b0;
            start_i = 1'b0;
            decrypt_i = 1'b0;
        end
        if (lat < 0) check("done_timeout", 1'b0, 1'b1);
        check("busy_at_done", busy_o, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check("done_one_cycle", done_o, 1'b0);
        check("hs_count", hs_count, n);
        if (hs_log.size() == n) begin
            for (int k = 0; k < n; k++) begin
                logic [1:0] eop;
                logic [3:0] eidx;
                if (dec && k < 10) begin eop = 2'd2; eidx = 4'(k + 1); end
                else if (dec)      begin eop = 2'd1; eidx = 4'(20 - k); end
                else               begin eop = 2'd0; eidx = 4'(k + 1); end
                if (hs_log[k] !== {eop, eidx, (eop == 2'd1) ? (eidx == 4'd1) : (eop == 2'd0 && eidx == 4'd10)})
                    bad++;
            end
            check("hs_sequence", bad, 0);
        end
        read_result(res);
    endtask

    typedef struct {
        logic         dec;
        logic [127:0] blk;
        logic [127:0] key;
        int           delay;
        logic [127:0] exp;
        int           exp_lat;
    } vec_t;

    task automatic apply_stimulus(input vec_t v, input string name);
        int lat;
        logic [127:0] res;
        max_delay = v.delay;
        load_block(v.blk, v.key);
        run_op(v.dec, 1'b0, 4'd0, 16'h0, 1'b0, lat, res);
        if (v.exp_lat >= 0) check({name, "_latency"}, lat, v.exp_lat);
        check({name, "_result"}, res, v.exp);
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        vec_t vecs [6];
        int lat;
        int n;
        int dc;
        logic [127:0] res;
        logic [127:0] blk;
        logic [127:0] key;
        logic [15:0] d;
        logic dec;

        vecs[0] = '{1'b0, FIPS_PT, FIPS_KEY, 0, FIPS_CT, 13};
        vecs[1] = '{1'b1, FIPS_CT, FIPS_KEY, 0, FIPS_PT, 23};
        vecs[2] = '{1'b0, C1_PT,   C1_KEY,   0, C1_CT,   13};
        vecs[3] = '{1'b1, C1_CT,   C1_KEY,   3, C1_PT,   -1};
        vecs[4] = '{1'b0, FIPS_PT, FIPS_KEY, 5, FIPS_CT, -1};
        vecs[5] = '{1'b1, FIPS_CT, FIPS_KEY, 5, FIPS_PT, -1};

        init_tables();
        reset = 1'b1;
        wr_en_i = 1'b0;
        wr_addr_i = '0;
        wr_data_i = '0;
        start_i = 1'b0;
        decrypt_i = 1'b0;
        rd_addr_i = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", busy_o, 1'b0);
        check("reset_done", done_o, 1'b0);
        check("reset_req", rnd_req_o, 1'b0);
        check("reset_idx", rnd_idx_o, 4'd0);
        check("reset_state", rnd_state_o, 128'h0);
        check("reset_key", rnd_key_o, 128'h0);
        read_result(res);
        check("reset_rd_data", res, 128'h0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) apply_stimulus(vecs[i], $sformatf("vec%0d", i));

        // Randomised blocks, keys, modes and ack delays against the reference.
        for (int i = 0; i < 8; i++) begin
            dec = 1'($urandom);
            blk = {$urandom, $urandom, $urandom, $urandom};
            key = {$urandom, $urandom, $urandom, $urandom};
            max_delay = int'($urandom_range(0, 5));
            load_block(blk, key);
            run_op(dec, 1'b0, 4'd0, 16'h0, 1'b0, lat, res);
            check($sformatf("rand%0d_result", i), res, aes_ref(dec, blk, key));
        end

        // Write and second start while busy must be ignored.
        max_delay = 2;
        load_block(FIPS_PT, FIPS_KEY);
        run_op(1'b0, 1'b0, 4'd0, 16'h0, 1'b1, lat, res);
        check("busy_ignore_result", res, FIPS_CT);

        // Write in the start cycle is used by the operation.
        max_delay = 0;
        d = 16'($urandom);
        blk = FIPS_PT;
        blk[79:64] = ~d;
        load_block(blk, FIPS_KEY);
        blk[79:64] = d;
        run_op(1'b0, 1'b1, 4'd3, d, 1'b0, lat, res);
        check("same_cycle_wr_result", res, aes_ref(1'b0, blk, FIPS_KEY));

        // Reset during round 5 aborts with no done pulse.
        max_delay = 0;
        load_block(FIPS_PT, FIPS_KEY);
        start_i = 1'b1;
        decrypt_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        n = 0;
        while (!(rnd_req_o && rnd_idx_o == 4'd5) && n < 100) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        check("reach_round5", (n < 100), 1'b1);
        dc = done_count;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_busy", busy_o, 1'b0);
        check("abort_req", rnd_req_o, 1'b0);
        read_result(res);
        check("abort_rd_data", res, 128'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("abort_no_done", done_count, dc);
        check("abort_idle", busy_o, 1'b0);

        load_block(FIPS_PT, FIPS_KEY);
        run_op(1'b0, 1'b0, 4'd0, 16'h0, 1'b0, lat, res);
        check("after_abort_latency", lat, 13);
        check("after_abort_result", res, FIPS_CT);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
